// File: rtl/ring_osc_trim_ctrl.sv
// Ring-oscillator frequency calibration: counts osc edges per window and steps a thermometer trim word.
// Define TRIM_CTRL_TRACK_EN to keep re-measuring from HOLD instead of freezing after the first result.
module ring_osc_trim_ctrl #(
    parameter int CNT_W         = 16,
    parameter int WINDOW_LOG2   = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int RST_CYCLES    = 4
) (
    input  logic             clk_i,
    input  logic             resetb_i,
    input  logic             osc_clk_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic [7:0]       tol_i,
    output logic             osc_reset_o,
    output logic [25:0]      trim_o,
    output logic [CNT_W-1:0] meas_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             sat_o
);
    localparam int TMR_W = (WINDOW_LOG2 > 15) ? WINDOW_LOG2 + 1 : 16;
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'((1 << WINDOW_LOG2) - 1);
    localparam logic [4:0]       LEVEL_MAX   = 5'd26;
    localparam logic [4:0]       LEVEL_RST   = 5'd13;

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_OSC, S_SETTLE, S_MEASURE, S_ADJUST, S_HOLD
    } state_t;

    // Oscillator domain: binary count kept alongside a registered Gray copy for safe crossing.
    logic [CNT_W-1:0] osc_bin_q;
    logic [CNT_W-1:0] osc_gray_q;
    logic [CNT_W-1:0] osc_bin_d;

    assign osc_bin_d = osc_bin_q + CNT_W'(1);

    always_ff @(posedge osc_clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            osc_bin_q  <= '0;
            osc_gray_q <= '0;
        end else begin
            osc_bin_q  <= osc_bin_d;
            osc_gray_q <= osc_bin_d ^ (osc_bin_d >> 1);
        end
    end

    logic [CNT_W-1:0] sync1_q;
    logic [CNT_W-1:0] sync2_q;
    logic [CNT_W-1:0] snap_bin;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= osc_gray_q;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_gray2bin
            assign snap_bin[gi] = ^sync2_q[CNT_W-1:gi];
        end
    endgenerate

    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [4:0]       level_q;
    logic [25:0]      trim_q;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] end_q;
    logic [CNT_W-1:0] meas_q;
    logic             osc_reset_q;
    logic             busy_q;
    logic             locked_q;
    logic             sat_q;

    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] tol_ext;
    logic [CNT_W:0]   hi_sum;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;

    // Modular difference absorbs counter wrap within one window.
    assign diff    = end_q - start_q;
    assign tol_ext = CNT_W'(tol_i);
    assign hi_sum  = {1'b0, target_i} + {1'b0, tol_ext};
    assign hi      = hi_sum[CNT_W] ? '1 : hi_sum[CNT_W-1:0];
    assign lo      = (target_i < tol_ext) ? '0 : target_i - tol_ext;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            level_q     <= LEVEL_RST;
            trim_q      <= 26'h0001FFF;
            start_q     <= '0;
            end_q       <= '0;
            meas_q      <= '0;
            osc_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            sat_q       <= 1'b0;
        end else if (!enable_i) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            osc_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_RESET_OSC;
                    busy_q  <= 1'b1;
                    tmr_q   <= '0;
                end
                S_RESET_OSC: begin
                    if (tmr_q == RST_LAST) begin
                        state_q     <= S_SETTLE;
                        osc_reset_q <= 1'b0;
                        tmr_q       <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        start_q <= snap_bin;
                        state_q <= S_MEASURE;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (tmr_q == WIN_LAST) begin
                        end_q   <= snap_bin;
                        state_q <= S_ADJUST;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_ADJUST: begin
                    meas_q <= diff;
                    tmr_q  <= '0;
                    // Higher level = slower oscillator, so a high count steps the level up.
                    if (diff > hi && level_q < LEVEL_MAX) begin
                        level_q  <= level_q + 5'd1;
                        trim_q   <= {trim_q[24:0], 1'b1};
                        locked_q <= 1'b0;
                        state_q  <= S_SETTLE;
                    end else if (diff < lo && level_q != 5'd0) begin
                        level_q  <= level_q - 5'd1;
                        trim_q   <= {1'b0, trim_q[25:1]};
                        locked_q <= 1'b0;
                        state_q  <= S_SETTLE;
                    end else if (diff >= lo && diff <= hi) begin
                        locked_q <= 1'b1;
                        sat_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= S_HOLD;
                    end else begin
                        sat_q    <= 1'b1;
                        locked_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
`ifdef TRIM_CTRL_TRACK_EN
                    state_q <= S_SETTLE;
                    busy_q  <= 1'b1;
                    tmr_q   <= '0;
`else
                    state_q <= S_HOLD;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign osc_reset_o = osc_reset_q;
    assign trim_o      = trim_q;
    assign meas_o      = meas_q;
    assign busy_o      = busy_q;
    assign locked_o    = locked_q;
    assign sat_o       = sat_q;
endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// Directed bench for ring_osc_trim_ctrl with a behavioural oscillator whose period grows with trim level.
`timescale 1ps/1ps
module tb_ring_osc_trim_ctrl;
    logic        clk    = 1'b0;
    logic        resetb = 1'b0;
    logic        osc_clk = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] target = 16'd0;
    logic [7:0]  tol    = 8'd0;
    logic        osc_reset;
    logic [25:0] trim;
    logic [15:0] meas;
    logic        busy;
    logic        locked;
    logic        sat;

    int n_checks = 0;
    int n_fail   = 0;

    ring_osc_trim_ctrl dut (
        .clk_i       (clk),
        .resetb_i    (resetb),
        .osc_clk_i   (osc_clk),
        .enable_i    (enable),
        .target_i    (target),
        .tol_i       (tol),
        .osc_reset_o (osc_reset),
        .trim_o      (trim),
        .meas_o      (meas),
        .busy_o      (busy),
        .locked_o    (locked),
        .sat_o       (sat)
    );

    always #5000 clk = ~clk;

    // Period (ps) = 4598 + 54*level: level 13 -> ~483 edges/window, level 6 -> ~520, level 26 -> ~426.
    initial forever begin
        if (osc_reset !== 1'b0) begin
            osc_clk = 1'b0;
            #1000;
        end else begin
            #((4598 + 54 * $countones(trim)) / 2) osc_clk = ~osc_clk;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_not_busy(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (busy && cycles < limit);
    endtask

    task automatic test_reset;
        resetb = 1'b0; enable = 1'b0; target = 16'd483; tol = 8'd4;
        tick(3);
        n_checks++; if (trim !== 26'h0001FFF) begin n_fail++; $display("FAIL reset_trim: got %h expected %h", trim, 26'h0001FFF); end
        n_checks++; if (osc_reset !== 1'b1) begin n_fail++; $display("FAIL reset_osc_reset: got %b expected 1", osc_reset); end
        n_checks++; if (locked !== 1'b0 || busy !== 1'b0 || sat !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got locked=%b busy=%b sat=%b expected 0 0 0", locked, busy, sat); end
        n_checks++; if (meas !== 16'd0) begin n_fail++; $display("FAIL reset_meas: got %0d expected 0", meas); end
        resetb = 1'b1;
        tick(10);
        n_checks++; if (trim !== 26'h0001FFF || osc_reset !== 1'b1) begin n_fail++; $display("FAIL idle_hold: got trim=%h osc_reset=%b expected 0001fff 1", trim, osc_reset); end
        n_checks++; if (busy !== 1'b0 || locked !== 1'b0 || meas !== 16'd0) begin n_fail++; $display("FAIL idle_flags: got busy=%b locked=%b meas=%0d expected 0 0 0", busy, locked, meas); end
        $display("reset: trim=%h osc_reset=%b meas=%0d", trim, osc_reset, meas);
    endtask

    task automatic test_lock_483;
        int c;
        target = 16'd483; tol = 8'd4; enable = 1'b1;
        tick(1);
        n_checks++; if (busy !== 1'b1 || osc_reset !== 1'b1) begin n_fail++; $display("FAIL lock_start: got busy=%b osc_reset=%b expected 1 1", busy, osc_reset); end
        tick(3);
        n_checks++; if (osc_reset !== 1'b1) begin n_fail++; $display("FAIL osc_reset_4th: got %b expected 1", osc_reset); end
        tick(1);
        n_checks++; if (osc_reset !== 1'b0) begin n_fail++; $display("FAIL osc_reset_release: got %b expected 0", osc_reset); end
        wait_not_busy(400, c);
        n_checks++; if (c + 5 !== 278) begin n_fail++; $display("FAIL first_adjust_latency: got %0d expected 278", c + 5); end
        n_checks++; if (meas < 16'd479 || meas > 16'd487) begin n_fail++; $display("FAIL lock483_meas: got %0d expected 479..487", meas); end
        n_checks++; if (locked !== 1'b1 || sat !== 1'b0) begin n_fail++; $display("FAIL lock483_flags: got locked=%b sat=%b expected 1 0", locked, sat); end
        n_checks++; if (trim !== 26'h0001FFF) begin n_fail++; $display("FAIL lock483_trim: got %h expected 0001fff", trim); end
        $display("lock483: meas=%0d trim=%h locked=%b cycles=%0d", meas, trim, locked, c + 5);
    endtask

    task automatic test_abort;
        logic [15:0] saved_meas;
        logic [25:0] saved_trim;
        enable = 1'b0;
        tick(2);
        n_checks++; if (busy !== 1'b0 || osc_reset !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL disable_idle: got busy=%b osc_reset=%b locked=%b expected 0 1 0", busy, osc_reset, locked); end
        saved_meas = meas;
        enable = 1'b1;
        tick(121);
        n_checks++; if (busy !== 1'b1 || osc_reset !== 1'b0) begin n_fail++; $display("FAIL mid_measure: got busy=%b osc_reset=%b expected 1 0", busy, osc_reset); end
        saved_trim = trim;
        enable = 1'b0;
        tick(1);
        n_checks++; if (osc_reset !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_next_cycle: got osc_reset=%b busy=%b expected 1 0", osc_reset, busy); end
        tick(300);
        n_checks++; if (meas !== saved_meas) begin n_fail++; $display("FAIL abort_meas: got %0d expected %0d", meas, saved_meas); end
        n_checks++; if (trim !== saved_trim) begin n_fail++; $display("FAIL abort_trim: got %h expected %h", trim, saved_trim); end
        $display("abort: meas=%0d trim=%h busy=%b", meas, trim, busy);
    endtask

    task automatic test_step_down;
        int c;
        target = 16'd520; tol = 8'd4; enable = 1'b1;
        wait_not_busy(3000, c);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_down_timeout: got busy=%b after %0d cycles expected 0", busy, c); end
        n_checks++; if (trim !== 26'h3F && trim !== 26'h1F) begin n_fail++; $display("FAIL step_down_trim: got %h expected 3f or 1f", trim); end
        n_checks++; if (locked !== 1'b1 || sat !== 1'b0) begin n_fail++; $display("FAIL step_down_flags: got locked=%b sat=%b expected 1 0", locked, sat); end
        n_checks++; if (meas < 16'd516 || meas > 16'd524) begin n_fail++; $display("FAIL step_down_meas: got %0d expected 516..524", meas); end
        $display("step_down: meas=%0d trim=%h cycles=%0d", meas, trim, c);
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_saturate;
        int c;
        target = 16'd400; tol = 8'd4; enable = 1'b1;
        wait_not_busy(7000, c);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL saturate_timeout: got busy=%b after %0d cycles expected 0", busy, c); end
        n_checks++; if (trim !== 26'h3FFFFFF) begin n_fail++; $display("FAIL saturate_trim: got %h expected 3ffffff", trim); end
        n_checks++; if (sat !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL saturate_flags: got sat=%b locked=%b expected 1 0", sat, locked); end
        $display("saturate: meas=%0d trim=%h sat=%b cycles=%0d", meas, trim, sat, c);
        enable = 1'b0;
        tick(2);
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL idle_clears_sat: got %b expected 0", sat); end
    endtask

    task automatic test_bounds;
        int c;
        // target+tol overflows: bound must clamp, so a ~426 count is low and level steps down.
        target = 16'hFFFE; tol = 8'd4; enable = 1'b1;
        tick(279);
        n_checks++; if (trim !== 26'h1FFFFFF || busy !== 1'b1) begin n_fail++; $display("FAIL hi_clamp: got trim=%h busy=%b expected 1ffffff 1", trim, busy); end
        enable = 1'b0;
        tick(2);
        // target-tol underflows: bound must clamp at 0, so the count is high and level steps up.
        target = 16'd2; tol = 8'd4; enable = 1'b1;
        tick(279);
        n_checks++; if (trim !== 26'h3FFFFFF || busy !== 1'b1) begin n_fail++; $display("FAIL lo_clamp: got trim=%h busy=%b expected 3ffffff 1", trim, busy); end
        wait_not_busy(400, c);
        n_checks++; if (sat !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL lo_clamp_sat: got sat=%b busy=%b expected 1 0", sat, busy); end
        $display("bounds: trim=%h sat=%b", trim, sat);
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_async_reset;
        target = 16'd483; tol = 8'd4; enable = 1'b1;
        tick(50);
        #2000;
        resetb = 1'b0;
        enable = 1'b0;
        #1;
        n_checks++; if (trim !== 26'h0001FFF || busy !== 1'b0 || osc_reset !== 1'b1) begin n_fail++; $display("FAIL async_reset: got trim=%h busy=%b osc_reset=%b expected 0001fff 0 1", trim, busy, osc_reset); end
        n_checks++; if (meas !== 16'd0) begin n_fail++; $display("FAIL async_reset_meas: got %0d expected 0", meas); end
        tick(2);
        resetb = 1'b1;
        tick(2);
        $display("async_reset: trim=%h meas=%0d", trim, meas);
    endtask

    task automatic test_retarget;
        int c;
        logic [15:0] saved_meas;
        target = 16'd483; tol = 8'd4; enable = 1'b1;
        wait_not_busy(400, c);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL retarget_prelock: got %b expected 1", locked); end
        saved_meas = meas;
        target = 16'd520;
`ifdef TRIM_CTRL_TRACK_EN
        c = 0;
        while (locked && c < 600) begin tick(1); c++; end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL track_unlock: got %b expected 0", locked); end
        c = 0;
        while (!locked && c < 3000) begin tick(1); c++; end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL track_relock: got %b expected 1", locked); end
        n_checks++; if (trim !== 26'h3F && trim !== 26'h1F) begin n_fail++; $display("FAIL track_trim: got %h expected 3f or 1f", trim); end
`else
        tick(600);
        n_checks++; if (trim !== 26'h0001FFF || locked !== 1'b1) begin n_fail++; $display("FAIL hold_frozen: got trim=%h locked=%b expected 0001fff 1", trim, locked); end
        n_checks++; if (meas !== saved_meas || busy !== 1'b0) begin n_fail++; $display("FAIL hold_meas: got meas=%0d busy=%b expected %0d 0", meas, busy, saved_meas); end
`endif
        $display("retarget: trim=%h locked=%b meas=%0d", trim, locked, meas);
        enable = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_lock_483();
        test_abort();
        test_step_down();
        test_saturate();
        test_bounds();
        test_async_reset();
        test_retarget();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
